// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM byte-strobe write port of the boot loader.
interface ram_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ram_w;
  logic [31:0] ram_addr;
  logic [31:0] ram_in;

  modport master (output in_data, in_valid, input in_ready, ram_w, ram_addr, ram_in);
  modport slave  (input in_data, in_valid, output in_ready, ram_w, ram_addr, ram_in);
endinterface

// File: rtl/ram_loader.sv
// Boot loader: little-endian word count + data bytes -> RAM words, then releases the CPU.
// Define RAM_LOADER_CHECKSUM_EN to require a trailing mod-256 byte checksum before DONE.
//
// state   | meaning
// S_HDR   | collecting the 4 word-count bytes
// S_DATA  | assembling the 4 bytes of the next word
// S_WRITE | single-cycle RAM write of the assembled word
// S_CHK   | waiting for the checksum byte (checksum build only)
// S_DONE  | image loaded, CPU released, input discarded
// S_ERROR | protocol error, CPU held in reset, input discarded
module ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_loader_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cpu_rst_n
);
  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_END   = S_CHK;
`else
  localparam logic [2:0] S_END   = S_DONE;
`endif

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] idx;
  logic [31:0] asm_word;
  logic        xfer;
  logic [31:0] hdr_full;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign xfer     = bus.in_valid && bus.in_ready;
  // Full count as it will be once the current (4th) byte lands.
  assign hdr_full = {bus.in_data, word_cnt[23:0]};

  assign bus.in_ready = (state != S_WRITE);
  assign bus.ram_w    = (state == S_WRITE) ? 4'hF : 4'h0;
  assign bus.ram_in   = (state == S_WRITE) ? asm_word : 32'h0;
  assign bus.ram_addr = BASE_ADDR + (idx << 2);

  assign done = (state == S_DONE);
  assign err  = (state == S_ERROR);
`ifdef RAM_LOADER_CHECKSUM_EN
  assign busy = (state == S_DATA) || (state == S_WRITE) || (state == S_CHK) ||
                ((state == S_HDR) && (byte_cnt != 2'd0));
`else
  assign busy = (state == S_DATA) || (state == S_WRITE) ||
                ((state == S_HDR) && (byte_cnt != 2'd0));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HDR;
      byte_cnt  <= 2'd0;
      word_cnt  <= 32'h0;
      idx       <= 32'h0;
      asm_word  <= 32'h0;
      cpu_rst_n <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      cpu_rst_n <= (state == S_DONE);
      case (state)
        S_HDR: if (xfer) begin
          word_cnt[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (hdr_full == 32'h0)            state <= S_END;
            else if (hdr_full > MAX_WORDS)    state <= S_ERROR;
            else                              state <= S_DATA;
          end
        end
        S_DATA: if (xfer) begin
          asm_word[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
          byte_cnt <= byte_cnt + 2'd1;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum <= sum + bus.in_data;
`endif
          if (byte_cnt == 2'd3) state <= S_WRITE;
        end
        S_WRITE: begin
          idx <= idx + 32'd1;
          state <= (idx + 32'd1 == word_cnt) ? S_END : S_DATA;
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        S_CHK: if (xfer) state <= (bus.in_data == sum) ? S_DONE : S_ERROR;
`endif
        S_DONE:  state <= S_DONE;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: vector table, directed corner sequences, random images.
module tb_ram_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int MAXW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err, cpu_rst_n;
  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] wr_q[$];
  logic [7:0] stream_q[$];

  ram_loader_if bus();
  ram_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n));

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Every RAM write is recorded; during a write the loader must stall input.
  always @(negedge clk) begin
    if (rst_n && bus.ram_w != 4'h0) begin
      wr_q.push_back({bus.ram_addr, bus.ram_in});
      check("wr_strobe", 64'(bus.ram_w), 64'hF);
      check("wr_in_ready", 64'(bus.in_ready), 64'h0);
    end
  end

  typedef struct {
    logic [31:0] n;
    int          nw;
    logic [31:0] w0, w1, w2;
    int          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;
  vec_t vecs[6];

  function automatic void push_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) stream_q.push_back(w[8*k +: 8]);
  endfunction

  function automatic logic [7:0] csum();
    logic [7:0] s = 8'h00;
    for (int i = 4; i < stream_q.size(); i++) s = s + stream_q[i];
    return s;
  endfunction

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 64'(t < 50), 64'h1);
    if (t < 50) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap_mode);
    for (int i = 0; i < stream_q.size(); i++)
      send_byte(stream_q[i], (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode);
  endtask

  // Streams one image (junk after the header when it is expected to be rejected)
  // and checks final status plus every RAM write against the supplied words.
  task automatic run_image(input logic [31:0] n, input logic [31:0] words[$], input int gap_mode,
                           input bit exp_done, input bit exp_err, input int exp_writes);
    stream_q.delete();
    push_word(n);
    if (exp_err) push_word(32'hA5A5_5A5A);
    else begin
      foreach (words[i]) push_word(words[i]);
`ifdef RAM_LOADER_CHECKSUM_EN
      stream_q.push_back(csum());
`endif
    end
    send_stream(gap_mode);
    repeat (3) @(negedge clk);
    check("img_done", 64'(done), 64'(exp_done));
    check("img_err", 64'(err), 64'(exp_err));
    check("img_busy", 64'(busy), 64'h0);
    check("img_cpu_rst_n", 64'(cpu_rst_n), 64'(exp_done));
    check("img_nwrites", 64'(wr_q.size()), 64'(exp_writes));
    for (int i = 0; i < exp_writes && i < wr_q.size(); i++)
      check("img_write", wr_q[i], {BASE + 32'(4 * i), words[i]});
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] n;
    bit ok;

    vecs[0] = '{32'd1,          1, 32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 0, 1};
    vecs[1] = '{32'd3,          3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 1, 1, 0, 3};
    vecs[2] = '{32'd33,         0, 32'h0,        32'h0,        32'h0,        0, 0, 1, 0};
    vecs[3] = '{32'd0,          0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0};
    vecs[4] = '{32'd2,          2, 32'hCAFEF00D, 32'h01020304, 32'h0,        2, 1, 0, 2};
    vecs[5] = '{32'h0001_0001,  0, 32'h0,        32'h0,        32'h0,        0, 0, 1, 0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    check("rst_ram_w", 64'(bus.ram_w), 64'h0);
    check("rst_ram_addr", 64'(bus.ram_addr), 64'(BASE));
    check("rst_ram_in", 64'(bus.ram_in), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word: write cycle right after the 4th data byte, CPU released a cycle after DONE.
    send_byte(8'h01, 0);
    check("busy_after_hdr_byte", 64'(busy), 64'h1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0);
    @(negedge clk);
    bus.in_data = 8'hDE;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("w1_ram_w", 64'(bus.ram_w), 64'hF);
    check("w1_ram_addr", 64'(bus.ram_addr), 64'(BASE));
    check("w1_ram_in", 64'(bus.ram_in), 64'hDEADBEEF);
    check("w1_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk); #1;
    check("w1_ram_w_after", 64'(bus.ram_w), 64'h0);
    check("w1_next_addr", 64'(bus.ram_addr), 64'(BASE + 32'd4));
`ifdef RAM_LOADER_CHECKSUM_EN
    check("w1_not_done_before_chk", 64'(done), 64'h0);
    send_byte(8'h38, 0);
`endif
    check("w1_done", 64'(done), 64'h1);
    check("w1_cpu_still_held", 64'(cpu_rst_n), 64'h0);
    @(posedge clk); #1;
    check("w1_cpu_released", 64'(cpu_rst_n), 64'h1);
    send_byte(8'h77, 0);
    check("w1_done_sticky", 64'(done), 64'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_cpu", 64'(cpu_rst_n), 64'h0);
    check("async_rst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      do_reset();
      wq.delete();
      if (vecs[v].nw > 0) wq.push_back(vecs[v].w0);
      if (vecs[v].nw > 1) wq.push_back(vecs[v].w1);
      if (vecs[v].nw > 2) wq.push_back(vecs[v].w2);
      run_image(vecs[v].n, wq, vecs[v].gap, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes);
    end

    // Asynchronous reset after 2 of 3 words, then a clean single-word load.
    do_reset();
    stream_q.delete();
    push_word(32'd3);
    push_word(32'h0A0B0C0D);
    push_word(32'h10203040);
    send_stream(0);
    repeat (2) @(negedge clk);
    check("mid_nwrites", 64'(wr_q.size()), 64'h2);
    check("mid_busy", 64'(busy), 64'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_in_ready", 64'(bus.in_ready), 64'h1);
    check("mid_ram_w", 64'(bus.ram_w), 64'h0);
    check("mid_ram_addr", 64'(bus.ram_addr), 64'(BASE));
    check("mid_ram_in", 64'(bus.ram_in), 64'h0);
    check("mid_busy_clr", 64'(busy), 64'h0);
    check("mid_done", 64'(done), 64'h0);
    check("mid_err", 64'(err), 64'h0);
    check("mid_cpu_rst_n", 64'(cpu_rst_n), 64'h0);
    @(negedge clk);
    wr_q.delete();
    rst_n = 1'b1;
    wq.delete();
    wq.push_back(32'h0BADC0DE);
    run_image(32'd1, wq, 0, 1, 0, 1);

`ifdef RAM_LOADER_CHECKSUM_EN
    for (int c = 0; c < 2; c++) begin
      do_reset();
      stream_q.delete();
      push_word(32'd1);
      push_word(32'h04030201);
      stream_q.push_back((c == 0) ? 8'h0A : 8'h0B);
      send_stream(0);
      repeat (3) @(negedge clk);
      check("chk_done", 64'(done), 64'(c == 0));
      check("chk_err", 64'(err), 64'(c == 1));
      check("chk_cpu_rst_n", 64'(cpu_rst_n), 64'(c == 0));
      check("chk_nwrites", 64'(wr_q.size()), 64'h1);
    end
`endif

    // Random images against the model: N words land at consecutive addresses iff N <= MAXW.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      n = (it == 0) ? 32'd32 : (it == 1) ? 32'd33 : 32'($urandom_range(0, 36));
      ok = (n <= 32'(MAXW));
      wq.delete();
      if (ok) for (int i = 0; i < int'(n); i++) wq.push_back($urandom);
      run_image(n, wq, 2, ok, !ok, ok ? int'(n) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
